// File: rtl/key_scan_pkg.sv
// Shared types and elaboration-time helpers for the key scan controller.
package key_scan_pkg;

  // Widest key index the controller supports (up to 16 keys).
  localparam int KEY_FIELD_W = 4;

  // Generic event entry; the controller narrows the key field to its own width.
  typedef struct packed {
    logic [KEY_FIELD_W-1:0] key;
    logic                   press;
  } key_evt_t;

  // Number of consecutive visits a new level must survive before it is accepted.
  function automatic int calc_stable_scans(input int glitch_ns, input int clk_mhz,
                                           input int keys);
    int num;
    int den;
    int s;
    num = glitch_ns * clk_mhz;
    den = 1000 * keys;
    s   = (num + den - 1) / den;
    return (s < 1) ? 1 : s;
  endfunction

  // Bits needed to index KEYS_NUM keys (at least one).
  function automatic int key_idx_w(input int keys);
    return (keys > 1) ? $clog2(keys) : 1;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO holding debounced key events; full push is refused
// unless a pop frees a slot in the same cycle.
module key_event_fifo
  import key_scan_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = key_evt_t
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic                       push_i,
  input  entry_t                     data_i,
  input  logic                       pop_i,
  output entry_t                     data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// Round-robin key debouncer: one shared evaluation slot visits a key per
// enabled cycle, keeps per-key stability counters and queues edge events.
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter int KEYS_NUM       = 4,
  parameter int CLK_FREQ_MHZ   = 50,
  parameter int GLITCH_TIME_NS = 2000,
  parameter int EVT_DEPTH      = 4,
  parameter int REPORT_RELEASE = 0
) (
  input  logic                        clk_i,
  input  logic                        srst_i,
  input  logic                        enable_i,
  input  logic [KEYS_NUM-1:0]         key_i,
  output logic [KEYS_NUM-1:0]         key_state_o,
  output logic                        event_valid_o,
  output logic [$clog2(KEYS_NUM)-1:0] event_key_o,
  output logic                        event_press_o,
  input  logic                        event_ready_i,
  output logic                        overflow_o,
  input  logic                        clear_ovf_i
);

  localparam int STABLE_SCANS = calc_stable_scans(GLITCH_TIME_NS, CLK_FREQ_MHZ, KEYS_NUM);
  localparam int CNT_W        = $clog2(STABLE_SCANS + 1);
  localparam int IDX_W        = key_idx_w(KEYS_NUM);
  localparam int FCW          = $clog2(EVT_DEPTH + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_SCANS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEYS_NUM - 1);

  // Entry narrowed to this instance's key index width.
  typedef struct packed {
    logic [IDX_W-1:0] key;
    logic             press;
  } evt_t;

  logic [KEYS_NUM-1:0]            sync1_q, sync1_d;
  logic [KEYS_NUM-1:0]            sync2_q, sync2_d;
  logic [KEYS_NUM-1:0]            key_state_q, key_state_d;
  logic [KEYS_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]               scan_idx_q, scan_idx_d;
  logic                           ovf_q, ovf_d;

  logic     evt_push;
  evt_t     evt_data;
  evt_t     fifo_head;
  logic     fifo_full, fifo_empty, fifo_pop, drop;
  logic [FCW-1:0] fifo_cnt;

  // Synchronizers run unconditionally; the scan slot only evaluates while enabled.
  always_comb begin
    sync1_d     = key_i;
    sync2_d     = sync1_q;
    key_state_d = key_state_q;
    cnt_d       = cnt_q;
    scan_idx_d  = scan_idx_q;
    evt_push    = 1'b0;
    evt_data    = '0;
    if (enable_i) begin
      scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + 1'b1;
      if (sync2_q[scan_idx_q] == key_state_q[scan_idx_q]) begin
        // Level back at the debounced value: any partial count was a glitch.
        cnt_d[scan_idx_q] = '0;
      end else if (cnt_q[scan_idx_q] == LAST_CNT) begin
        key_state_d[scan_idx_q] = sync2_q[scan_idx_q];
        cnt_d[scan_idx_q]       = '0;
        evt_push                = sync2_q[scan_idx_q] || (REPORT_RELEASE != 0);
        evt_data.key            = scan_idx_q;
        evt_data.press          = sync2_q[scan_idx_q];
      end else begin
        cnt_d[scan_idx_q] = cnt_q[scan_idx_q] + 1'b1;
      end
    end
  end

  // Overflow is sticky; a drop in the same cycle as a clear keeps it set.
  always_comb begin
    fifo_pop = !fifo_empty && event_ready_i;
    drop     = evt_push && fifo_full && !fifo_pop;
    ovf_d    = ovf_q;
    if (clear_ovf_i) ovf_d = 1'b0;
    if (drop)        ovf_d = 1'b1;
  end

  // Scan, debounce and status registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      key_state_q <= '0;
      cnt_q       <= '0;
      scan_idx_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      key_state_q <= key_state_d;
      cnt_q       <= cnt_d;
      scan_idx_q  <= scan_idx_d;
      ovf_q       <= ovf_d;
    end
  end

  key_event_fifo #(
    .DEPTH   (EVT_DEPTH),
    .entry_t (evt_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .push_i  (evt_push),
    .data_i  (evt_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Occupancy and full flag must agree.
  a_full_cnt: assert property (@(posedge clk_i) disable iff (srst_i)
    fifo_full == (fifo_cnt == FCW'(EVT_DEPTH)));

  assign key_state_o   = key_state_q;
  assign event_valid_o = !fifo_empty;
  assign event_key_o   = fifo_head.key;
  assign event_press_o = fifo_head.press;
  assign overflow_o    = ovf_q;

endmodule

// File: doc/key_scan_ctrl.md
Name: key_scan_ctrl

Overview:
Scheduler that shares one debounce evaluation slot round-robin across KEYS_NUM raw key inputs, replacing per-key debouncers. It keeps a debounced state for every key and queues press/release events in a small FIFO with a valid/ready handshake toward the consumer. It sits between board key pins and the UI/event logic.

Parameters:
KEYS_NUM, 4, number of raw key inputs (2..16)
CLK_FREQ_MHZ, 50, clk_i frequency in MHz
GLITCH_TIME_NS, 2000, minimum stable time before a level change is accepted
EVT_DEPTH, 4, event FIFO depth (power of 2, >=2)
REPORT_RELEASE, 0, 1 = also queue release (1->0) events

Ports:
clk_i  in  1  clock, single domain
srst_i  in  1  reset, synchronous, active-high
enable_i  in  1  1 = scanning runs; 0 = scan paused
key_i  in  KEYS_NUM  raw asynchronous key levels, 1 = pressed
key_state_o  out  KEYS_NUM  debounced key levels
event_valid_o  out  1  event FIFO non-empty
event_key_o  out  $clog2(KEYS_NUM)  key index of head event
event_press_o  out  1  1 = press, 0 = release (head event)
event_ready_i  in  1  consumer accepts head event
overflow_o  out  1  sticky: an event was dropped
clear_ovf_i  in  1  clears overflow_o

Behaviour:
- Localparam STABLE_SCANS = max(1, ceil(GLITCH_TIME_NS*CLK_FREQ_MHZ / (1000*KEYS_NUM))); per-key counter width $clog2(STABLE_SCANS+1).
- Reset (srst_i=1 at clk edge): sync flops, key_state_o, all counters, scan_idx, FIFO pointers = 0; event_valid_o=0, overflow_o=0. Reset mid-operation discards queued events and partial counts.
- Sync: 2-flop synchronizer per key, always running (also while enable_i=0).
- Scan: scan_idx advances 0..KEYS_NUM-1 one per cycle while enable_i=1, wraps to 0; holds when enable_i=0. Exactly one key evaluated per enabled cycle.
- Evaluation of key k=scan_idx: if sync[k]==key_state[k], cnt[k]<=0. Else if cnt[k]==STABLE_SCANS-1: key_state[k]<=sync[k], cnt[k]<=0, generate event {k, sync[k]}. Else cnt[k]<=cnt[k]+1. A single visit with the original level restarts the count (glitch rejected).
- Event generation: press always; release only when REPORT_RELEASE=1. key_state_o updates even if the event is dropped.
- Latency: change on key_i held steady -> key_state_o/event after 2 sync cycles plus STABLE_SCANS visits of that key (worst case 2 + STABLE_SCANS*KEYS_NUM cycles); event_valid_o rises the cycle after the accepting evaluation.
- FIFO: push on generated event, pop on event_valid_o && event_ready_i. Outputs are the head entry, stable while valid && !ready. Push+pop in same cycle when full: both accepted, count unchanged. Push when full without pop: event dropped, overflow_o<=1. Push+pop when empty: no bypass; entry becomes head next cycle.
- overflow_o: set on drop, cleared by clear_ovf_i or srst_i; set wins over clear in the same cycle.
- Keys pressed during reset: key_state starts at 0, so a held key produces a press event after the normal stable time.

Decomposition:
- key_scan_pkg: typedef for event entry struct {key index, press bit}; function computing STABLE_SCANS; KEY_IDX_W constant helper.
- Sub-module key_event_fifo (synchronous FIFO, parameterised DEPTH and entry type, full/empty/count, push/pop). Scan FSM, counters and synchronizers stay in key_scan_ctrl.

Test Plan:
(KEYS_NUM=4, CLK_FREQ_MHZ=100, GLITCH_TIME_NS=120 -> STABLE_SCANS=3, EVT_DEPTH=4)
- Clean press: key_i=4'b0010 held, ready=1 -> key_state_o[1]=1 within 2+12 cycles; one event {key 1, press}; no event for other keys.
- Glitch: key 2 high for 1 visit then low -> key_state_o stays 0000, no event, cnt[2] returns to 0.
- Release with REPORT_RELEASE=0 vs 1: release key 1 after press -> no event vs one {key 1, release}; key_state_o[1]=0 in both.
- Backpressure/overflow: ready=0, press keys 0..3 then release and re-press key 0 -> 4 events queued in order 0,1,2,3, fifth dropped, overflow_o=1; ready=1 drains 4 events, overflow_o stays 1 until clear_ovf_i.
- Full push+pop: FIFO full, ready=1 in the same cycle a new press qualifies -> no drop, count stays 4, overflow_o=0.
- enable_i=0 mid-count and srst_i mid-operation: scan_idx/counters freeze while disabled and resume at same index; srst_i clears event_valid_o and key_state_o to 0 next cycle.
